operand_forward_ctrl: RTL

//  Sequencer for the EX-stage ALU operand muxes. Tracks the in-flight destination registers of the
//  EX, MEM and WB slots and drives alu_mux1/alu_mux2 source selects: 00 regfile/PC/imm, 01 EX/MEM ALU

---
 rtl/operand_forward_ctrl_pkg.sv | 45 ++++
 rtl/operand_forward_ctrl_if.sv | 33 +++
 rtl/operand_forward_ctrl_fwd_match.sv | 26 ++
 rtl/operand_forward_ctrl.sv | 86 ++++++++
 4 files changed

// File: rtl/operand_forward_ctrl_pkg.sv
// Shared select codes, ALU source codes and the pipeline slot record for the operand-forwarding sequencer.
// Slot index fields use REG_AW_DEF bits, so instances must keep REG_AW equal to it.
package operand_forward_ctrl_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int CNT_W_DEF  = 32;

  typedef enum logic [1:0] {
    SEL_REG   = 2'b00,
    SEL_EXMEM = 2'b01,
    SEL_MEMWB = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ALU_SRC_R1_R2  = 2'b00,
    ALU_SRC_R1_IMM = 2'b01,
    ALU_SRC_PC_IMM = 2'b10
  } alu_src_e;

  typedef logic [REG_AW_DEF-1:0] reg_idx_t;

  typedef struct packed {
    logic     vld;
    reg_idx_t rd;
    logic     reg_write;
    logic     mem_read;
    logic     use_rs1;
    logic     use_rs2;
    reg_idx_t rs1;
    reg_idx_t rs2;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  // x0 is hard-wired zero, so it can never be the source of a hazard.
  function automatic logic produces(slot_t prod, reg_idx_t src);
    return prod.vld && prod.reg_write && (prod.rd != '0) && (prod.rd == src);
  endfunction

  function automatic logic id_hits(slot_t prod, slot_t cons);
    return (cons.use_rs1 && produces(prod, cons.rs1)) ||
           (cons.use_rs2 && produces(prod, cons.rs2));
  endfunction

endpackage

// File: rtl/operand_forward_ctrl_if.sv
// ID-stage instruction fields, pipeline controls and operand-select results exchanged with the sequencer.
// master = decode/datapath side, slave = operand_forward_ctrl.
interface operand_forward_ctrl_if #(
  parameter int REG_AW = operand_forward_ctrl_pkg::REG_AW_DEF,
  parameter int CNT_W  = operand_forward_ctrl_pkg::CNT_W_DEF
);
  logic              id_valid_in;
  logic [REG_AW-1:0] id_rs1_in;
  logic [REG_AW-1:0] id_rs2_in;
  logic              id_use_rs1_in;
  logic              id_use_rs2_in;
  logic [REG_AW-1:0] id_rd_in;
  logic              id_reg_write_in;
  logic              id_mem_read_in;
  logic              stall_in;
  logic              flush_in;
  logic [1:0]        alu_mux1_src_out;
  logic [1:0]        alu_mux2_src_out;
  logic              stall_out;
  logic [CNT_W-1:0]  stall_cnt_out;

  modport master (
    output id_valid_in, id_rs1_in, id_rs2_in, id_use_rs1_in, id_use_rs2_in,
           id_rd_in, id_reg_write_in, id_mem_read_in, stall_in, flush_in,
    input  alu_mux1_src_out, alu_mux2_src_out, stall_out, stall_cnt_out
  );

  modport slave (
    input  id_valid_in, id_rs1_in, id_rs2_in, id_use_rs1_in, id_use_rs2_in,
           id_rd_in, id_reg_write_in, id_mem_read_in, stall_in, flush_in,
    output alu_mux1_src_out, alu_mux2_src_out, stall_out, stall_cnt_out
  );
endinterface

// File: rtl/operand_forward_ctrl_fwd_match.sv
// Per-operand forwarding comparator: picks the youngest in-flight producer of the EX source.
// Purely combinational, no backpressure.
module fwd_match
  import operand_forward_ctrl_pkg::*;
(
  input  logic     i_ex_vld,
  input  logic     i_use,
  input  reg_idx_t i_src,
  input  slot_t    i_mem,
  input  slot_t    i_wb,
  output fwd_sel_e o_sel
);

  // MEM is checked first: it holds the most recent write of the register.
  always_comb begin
    o_sel = SEL_REG;
    if (i_ex_vld && i_use) begin
      if (produces(i_mem, i_src)) begin
        o_sel = SEL_EXMEM;
      end else if (produces(i_wb, i_src)) begin
        o_sel = SEL_MEMWB;
      end
    end
  end

endmodule

// File: rtl/operand_forward_ctrl.sv
// EX operand-mux sequencer: tracks EX/MEM/WB destinations, forwards results, stalls ID on RAW hazards.
// Selects come from registered slots; stall_out is same-cycle on ID inputs; stall_in freezes all state.
module operand_forward_ctrl
  import operand_forward_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  operand_forward_ctrl_if.slave bus
);

  slot_t            r_ex;
  slot_t            r_mem;
  slot_t            r_wb;
  logic [CNT_W-1:0] r_stall_cnt;

  slot_t    w_id;
  fwd_sel_e w_sel1;
  fwd_sel_e w_sel2;
  logic     w_hazard;
  logic     w_stall;

  always_comb begin
    w_id           = SLOT_BUBBLE;
    w_id.vld       = bus.id_valid_in;
    w_id.rd        = reg_idx_t'(bus.id_rd_in[REG_AW-1:0]);
    w_id.reg_write = bus.id_reg_write_in;
    w_id.mem_read  = bus.id_mem_read_in;
    w_id.use_rs1   = bus.id_use_rs1_in;
    w_id.use_rs2   = bus.id_use_rs2_in;
    w_id.rs1       = reg_idx_t'(bus.id_rs1_in[REG_AW-1:0]);
    w_id.rs2       = reg_idx_t'(bus.id_rs2_in[REG_AW-1:0]);
  end

  // Without forwarding, a consumer waits until its producer reaches WB (write-first regfile).
  if (FWD_EN != 0) begin : g_fwd
    assign w_hazard = r_ex.mem_read && id_hits(r_ex, w_id);
  end else begin : g_nofwd
    assign w_hazard = id_hits(r_ex, w_id) || id_hits(r_mem, w_id);
  end

  assign w_stall = bus.id_valid_in && !bus.flush_in && !bus.stall_in && w_hazard;

  fwd_match u_match_op1 (
    .i_ex_vld (r_ex.vld),
    .i_use    (r_ex.use_rs1),
    .i_src    (r_ex.rs1),
    .i_mem    (r_mem),
    .i_wb     (r_wb),
    .o_sel    (w_sel1)
  );

  fwd_match u_match_op2 (
    .i_ex_vld (r_ex.vld),
    .i_use    (r_ex.use_rs2),
    .i_src    (r_ex.rs2),
    .i_mem    (r_mem),
    .i_wb     (r_wb),
    .o_sel    (w_sel2)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_ex        <= SLOT_BUBBLE;
      r_mem       <= SLOT_BUBBLE;
      r_wb        <= SLOT_BUBBLE;
      r_stall_cnt <= '0;
    end else if (!bus.stall_in) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= (bus.flush_in || w_stall) ? SLOT_BUBBLE : w_id;
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.alu_mux1_src_out = (FWD_EN != 0) ? w_sel1 : SEL_REG;
  assign bus.alu_mux2_src_out = (FWD_EN != 0) ? w_sel2 : SEL_REG;
  assign bus.stall_out        = w_stall;
  assign bus.stall_cnt_out    = r_stall_cnt;

endmodule
